// File: rtl/mem_port_ctrl.sv
// Memory port sequencer for the multicycle datapath: arbitrates instruction fetch
// against data load/store on the single memory port and times each access.
module mem_port_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  output logic fetch_gnt,
  output logic data_gnt,
  output logic IorD,
  output logic mem_rd,
  output logic mem_wr,
  output logic ir_write,
  output logic mdr_write,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  // state  | meaning
  // S_IDLE | port free, arbitrating fetch_req / data_req
  // S_ACC  | command cycle: grant pulse plus read or write strobe
  // S_WAIT | memory wait states, wait_cnt counting down
  // S_DONE | data valid / write complete: IR or MDR load, done pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [3:0]      LAT_M1     = 4'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          sel_data;
  logic          sel_store;
  logic          starved;
  logic          pick_data;
  logic          pick_fetch;

  // Data normally wins; a fetch that has watched STARVE_MAX data grants goes next.
  assign starved    = fetch_req && (starve_cnt == STARVE_TOP);
  assign pick_data  = data_req && !starved;
  assign pick_fetch = fetch_req && !pick_data;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      sel_data   <= 1'b0;
      sel_store  <= 1'b0;
      fetch_gnt  <= 1'b0;
      data_gnt   <= 1'b0;
      IorD       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      ir_write   <= 1'b0;
      mdr_write  <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fetch_gnt  <= 1'b0;
      data_gnt   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      ir_write   <= 1'b0;
      mdr_write  <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_data || pick_fetch) begin
            state     <= S_ACC;
            busy      <= 1'b1;
            sel_data  <= pick_data;
            sel_store <= pick_data && data_we;
            IorD      <= pick_data;
            fetch_gnt <= pick_fetch;
            data_gnt  <= pick_data;
            mem_wr    <= pick_data && data_we;
            mem_rd    <= !(pick_data && data_we);
            wait_cnt  <= LAT_M1;
            if (pick_fetch || !fetch_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_TOP)
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        S_ACC, S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state      <= S_DONE;
            ir_write   <= !sel_data;
            fetch_done <= !sel_data;
            mdr_write  <= sel_data && !sel_store;
            data_done  <= sel_data;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          IorD  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          IorD  <= 1'b0;
        end
      endcase
    end
  end

endmodule
